hs_ready_responder: RTL and testbench

//  Sink/responder end of the valid/ready handshake. Source holds valid high until ready;

---
 rtl/hs_ready_responder.sv | 130 +++++++++++++
 tb/tb_hs_ready_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hs_ready_responder.sv
// Sink end of a valid/ready handshake: paces a one-cycle ready pulse and buffers captured data in a show-ahead FIFO.
// Optional HS_PROTO_CHECK_EN adds a sticky proto_err output and a handshake assertion.
module hs_ready_responder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WAIT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [DATA_W-1:0]        data,
  input  logic [WAIT_W-1:0]        wait_cycles,
  output logic                     ready,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
`ifdef HS_PROTO_CHECK_EN
  ,
  output logic                     proto_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                wr_en;
  logic                rd_fire;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_WAIT;
          cnt_d   = wait_cycles;
        end
      end
      S_WAIT: begin
        if (!valid)              state_d = S_IDLE;
        else if (cnt_q != '0)    cnt_d   = cnt_q - 1'b1;
        else if (!full)          state_d = S_ACK;
      end
      S_ACK:     state_d = S_RELEASE;
      S_RELEASE: if (!valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ready is registered from the next state, so it is high exactly while the FSM sits in ACK.
  always_comb begin
    ready_d = (state_d == S_ACK);
    wr_en   = (state_q == S_ACK) && valid;
  end

  assign rd_fire = rd_en && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable because rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data;
  end

  assign ready   = ready_q;
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

`ifdef HS_PROTO_CHECK_EN
  logic violation;
  logic proto_err_q;

  always_comb begin
    violation = (((state_q == S_WAIT) || (state_q == S_ACK)) && !valid) ||
                ((state_q == S_RELEASE) && valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            proto_err_q <= 1'b0;
    else if (violation) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;

  a_ready_release: assert property (@(posedge clk) disable iff (rst)
    $rose(ready) |-> ##1 (!valid && !ready));
`endif

endmodule

// File: tb/tb_hs_ready_responder.sv
// Self-checking bench for hs_ready_responder: directed scenarios plus randomized transfers/pops
// against a queue-based FIFO model and latency rule (ready after W+1 edges unless full).
module tb_hs_ready_responder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int WAIT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [WAIT_W-1:0] wait_cycles;
  logic              ready;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [2:0]        count;
`ifdef HS_PROTO_CHECK_EN
  logic              proto_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model_q [$];

  hs_ready_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .data        (data),
    .wait_cycles (wait_cycles),
    .ready       (ready),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count)
`ifdef HS_PROTO_CHECK_EN
    ,
    .proto_err   (proto_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fifo(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, "_count"}, 32'(count), 32'(sz));
    check({tag, "_empty"}, 32'(empty), 32'(sz == 0));
    check({tag, "_full"},  32'(full),  32'(sz == DEPTH));
    check({tag, "_head"},  32'(rd_data), (sz == 0) ? 32'd0 : 32'(model_q[0]));
  endtask

  // One complete transfer while the model FIFO has room; optionally hold valid
  // one extra cycle (violation) and/or pop on the ACK closing edge.
  task automatic xfer(input logic [DATA_W-1:0] d, input int w, input bit hold, input bit pop);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    valid = 1'b1;
    data = d;
    wait_cycles = WAIT_W'(w);
    while (n < 64 && !seen) begin
      step();
      n++;
      if (n == 1) wait_cycles = WAIT_W'($urandom);
      if (ready === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      check("ready_timeout", 32'(seen), 32'd1);
      valid = 1'b0;
      step();
      return;
    end
    check("latency", 32'(n - 1), 32'(w + 1));
    rd_en = pop;
    step();
    rd_en = 1'b0;
    if (pop && model_q.size() > 0) void'(model_q.pop_front());
    model_q.push_back(d);
    check("ready_pulse", 32'(ready), 32'd0);
    check_fifo("xfer");
    if (hold) begin
      step();
      check("hold_ready", 32'(ready), 32'd0);
`ifdef HS_PROTO_CHECK_EN
      check("proto_err_set", 32'(proto_err), 32'd1);
`endif
    end
    valid = 1'b0;
    step();
    check("post_ready", 32'(ready), 32'd0);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    check_fifo("pop");
  endtask

  initial begin
    int  hit;
    bit  ok;
    rst = 1'b1;
    valid = 1'b0;
    rd_en = 1'b0;
    data = '0;
    wait_cycles = '0;
    repeat (2) step();
    check("rst_ready", 32'(ready), 32'd0);
    check_fifo("rst");
`ifdef HS_PROTO_CHECK_EN
    check("rst_proto_err", 32'(proto_err), 32'd0);
`endif
    rst = 1'b0;
    step();

    // pop on empty is ignored
    pop_one();

    // 1: W=1, A5
    xfer(8'hA5, 1, 1'b0, 1'b0);
    // 2: W=0, valid held one cycle past ready, then a normal transfer proves recovery
    xfer(8'h3C, 0, 1'b1, 1'b0);
    // 3: W=5
    xfer(8'h96, 5, 1'b0, 1'b0);
    // 4: fill, then fifth transfer stalls until a pop
    xfer(8'h11, 2, 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);

    valid = 1'b1;
    data = 8'h5C;
    wait_cycles = '0;
    hit = 0;
    repeat (6) begin
      step();
      if (ready) hit++;
    end
    check("full_no_ready", 32'(hit), 32'd0);
    check("full_head", 32'(rd_data), 32'(model_q[0]));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    void'(model_q.pop_front());
    check("unblock_ready_low", 32'(ready), 32'd0);
    check_fifo("unblock_pop");
    step();
    check("unblock_ready_high", 32'(ready), 32'd1);
    step();
    model_q.push_back(8'h5C);
    check("unblock_pulse", 32'(ready), 32'd0);
    check_fifo("unblock_write");
    valid = 1'b0;
    step();

    // 5: concurrent write and pop at count=2
    pop_one();
    pop_one();
    xfer(8'hE7, 0, 1'b0, 1'b1);
    check("concurrent_count", 32'(count), 32'd2);
    while (model_q.size() > 0) pop_one();

    // 6: reset asserted while ready is high
    valid = 1'b1;
    data = 8'h42;
    wait_cycles = '0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      step();
      if (ready) ok = 1'b1;
    end
    check("ack_reached", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(ready), 32'd0);
    model_q.delete();
    check_fifo("async_rst");
    valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    xfer(8'h77, 2, 1'b0, 1'b0);
    pop_one();

    // randomized transfers and pops
    for (int i = 0; i < 40; i++) begin
      if (model_q.size() < DEPTH && ($urandom_range(0, 2) != 0))
        xfer(DATA_W'($urandom), int'($urandom_range(0, 3)), 1'b0,
             (model_q.size() > 0) && ($urandom_range(0, 1) == 1));
      else
        pop_one();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
